// File: rtl/dualport_16x8_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port on a shared clock.
// Storage is a flop array with per-word async clear. A read of the address being written returns the new data.
module dualport_16x8_ram #(
  parameter int width   = 8,
  parameter int depth   = 16,
  parameter int add_bus = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ra,
  input  logic               wa,
  input  logic [width-1:0]   data_in,
  input  logic [add_bus-1:0] re_ad,
  input  logic [add_bus-1:0] wr_ad,
  output logic [width-1:0]   data_out
);

  logic [width-1:0] mem [depth];
  logic             collision;

  assign collision = wa && (re_ad == wr_ad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wa) begin
      mem[wr_ad] <= data_in;
    end
  end

  // Write-first: on a same-address collision the incoming word bypasses the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (ra) begin
      data_out <= collision ? data_in : mem[re_ad];
    end
  end

endmodule

// File: tb/tb_dualport_16x8_ram.sv
// Directed bench for dualport_16x8_ram: reset clearing, write/read, hold, write-disable,
// write-first collision and reset in the middle of a write.
module tb_dualport_16x8_ram;

  logic       clk;
  logic       rst;
  logic       ra;
  logic       wa;
  logic [7:0] data_in;
  logic [3:0] re_ad;
  logic [3:0] wr_ad;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  dualport_16x8_ram #(.width(8), .depth(16), .add_bus(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ra       (ra),
    .wa       (wa),
    .data_in  (data_in),
    .re_ad    (re_ad),
    .wr_ad    (wr_ad),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] expected);
    checks++;
    assert (data_out === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, data_out, expected);
      end
  endtask

  task automatic apply_stimulus(input logic r, input logic [3:0] radr,
                                input logic w, input logic [3:0] wadr,
                                input logic [7:0] din);
    ra      = r;
    re_ad   = radr;
    wa      = w;
    wr_ad   = wadr;
    data_in = din;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("reset_state", 8'h00);
    step();
    rst = 1'b1;

    // Load a nonzero value so the async clear has something visible to remove.
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'h3, 8'h3C);
    step();
    apply_stimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    step();
    check_output("preload_read_3", 8'h3C);

    #3;
    rst = 1'b0;
    #1;
    check_output("async_reset_immediate", 8'h00);
    #2;
    rst = 1'b1;
    apply_stimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    step();
    check_output("reset_cleared_3", 8'h00);

    // Basic write then read.
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'h5, 8'h7D);
    step();
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'h0, 8'hCC);
    step();
    apply_stimulus(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("read_0", 8'hCC);
    apply_stimulus(1'b1, 4'h5, 1'b0, 4'h0, 8'h00);
    step();
    check_output("read_5", 8'h7D);

    // Top address, then hold with ra low.
    apply_stimulus(1'b0, 4'h5, 1'b1, 4'hF, 8'hFF);
    step();
    check_output("hold_during_write", 8'h7D);
    apply_stimulus(1'b1, 4'hF, 1'b0, 4'h0, 8'h00);
    step();
    check_output("read_F", 8'hFF);
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("hold_1", 8'hFF);
    step();
    check_output("hold_2", 8'hFF);

    // Write disabled must not alter word 5.
    apply_stimulus(1'b0, 4'h0, 1'b0, 4'h5, 8'h11);
    step();
    apply_stimulus(1'b1, 4'h5, 1'b0, 4'h5, 8'h11);
    step();
    check_output("wa0_read_5", 8'h7D);
    step();
    check_output("wa0_read_5_again", 8'h7D);

    // Collision: write-first bypass, memory also updated.
    apply_stimulus(1'b1, 4'h9, 1'b1, 4'h9, 8'hA5);
    step();
    check_output("collision_bypass", 8'hA5);
    apply_stimulus(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("read_0_after_coll", 8'hCC);
    apply_stimulus(1'b1, 4'h9, 1'b0, 4'h0, 8'h00);
    step();
    check_output("read_9_after_coll", 8'hA5);

    // Independent read and write at different addresses.
    apply_stimulus(1'b1, 4'h5, 1'b1, 4'h3, 8'h5A);
    step();
    check_output("indep_read_5", 8'h7D);
    apply_stimulus(1'b1, 4'h3, 1'b0, 4'h0, 8'h00);
    step();
    check_output("indep_read_3", 8'h5A);

    // Reset asserted for a cycle while a write is pending.
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'h0, 8'h77);
    rst = 1'b0;
    #1;
    check_output("midop_reset_immediate", 8'h00);
    step();
    check_output("midop_reset_held", 8'h00);
    rst = 1'b1;
    apply_stimulus(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("post_reset_read_0", 8'h00);
    apply_stimulus(1'b1, 4'h5, 1'b0, 4'h0, 8'h00);
    step();
    check_output("post_reset_read_5", 8'h00);
    apply_stimulus(1'b1, 4'hF, 1'b0, 4'h0, 8'h00);
    step();
    check_output("post_reset_read_F", 8'h00);
    apply_stimulus(1'b1, 4'h9, 1'b0, 4'h0, 8'h00);
    step();
    check_output("post_reset_read_9", 8'h00);

    // Memory still writable after reset.
    apply_stimulus(1'b0, 4'h0, 1'b1, 4'h0, 8'h42);
    step();
    apply_stimulus(1'b1, 4'h0, 1'b0, 4'h0, 8'h00);
    step();
    check_output("post_reset_write_0", 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
